cmd_bus_sequencer: RTL and testbench
====================================

Name: cmd_bus_sequencer

Overview:
- Executes decoded ASCII commands (Cmd/CmdAddr/CmdData/CmdValid from the command interpreter) as single transactions on the shared register bus.
- Formats an ASCII response byte stream towards the UART transmitter.
- Sits between the command interpreter, the register bus fabric and the TX path.
- Owns bus-timeout detection and counts commands dropped while busy.

Parameters:
- TIMEOUT_CYCLES, 255: BusReq-high cycles without BusAck before abort; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the timeout counter.

Ports:
- Clk  input  1  system clock, rising edge.
- RstN  input  1  reset, synchronous, active-low.
- Cmd  input  4  4'h1 = read, 4'h2 = write, other values = invalid.
- CmdAddr  input  32  command address.
- CmdData  input  32  write data.
- CmdValid  input  1  single-cycle command strobe.
- Busy  output  1  high whenever state != IDLE.
- BusReq  output  1  bus request, held until ack or timeout.
- BusWe  output  1  1 = write, 0 = read; valid while BusReq is high.
- BusAddr  output  32  latched CmdAddr.
- BusWData  output  32  latched CmdData.
- BusAck  input  1  single-cycle completion; only meaningful while BusReq is high.
- BusRData  input  32  read data, valid in the BusAck cycle.
- TxChar  output  8  response byte.
- TxValid  output  1  response byte valid.
- TxReady  input  1  TX accepts the byte when TxValid && TxReady.
- DropCnt  output  8  saturating count of commands dropped while Busy.

Behaviour:
- Reset:
  - RstN low at a rising edge puts the block in IDLE at that edge.
  - All outputs become 0 (BusAddr, BusWData, TxChar, DropCnt included). The timeout counter and response registers clear.
  - An outstanding bus request is abandoned: BusReq deasserts immediately and no response is emitted.
- States: IDLE, BUS, HEX, STAT, CR, LF.
- IDLE:
  - On CmdValid with Cmd = 1 or 2: latch CmdAddr/CmdData, set BusWe = (Cmd == 2), go to BUS.
  - BusReq = 1 starts the next cycle (1-cycle latency).
  - On CmdValid with any other Cmd: no bus access. Load status byte "E" (0x45) and go to STAT.
- BUS:
  - BusReq stays high; the timeout counter increments each cycle BusAck is low.
  - BusAck high:
    - BusReq = 0 the next cycle.
    - Read: latch BusRData, go to HEX.
    - Write: load "K" (0x4B), go to STAT.
  - Counter reaches TIMEOUT_CYCLES with BusAck low: BusReq = 0, load "E", go to STAT.
  - BusAck in the same cycle the counter would expire: ack wins.
- HEX:
  - Emits 8 chars, most-significant nibble first.
  - Nibble 0-9 maps to 0x30-0x39; A-F maps to uppercase 0x41-0x46.
  - After the 8th accepted char, go to CR.
- STAT: emit the loaded status byte, then go to CR.
- CR: emit 0x0D, then go to LF.
- LF: emit 0x0A, then go to IDLE.
- TX handshake (applies to HEX, STAT, CR and LF):
  - TxValid = 1 and TxChar is stable from state entry until accepted.
  - Advance only on TxValid && TxReady.
  - After the LF is accepted, TxValid = 0 the following cycle.
  - Back-to-back acceptance sends 1 byte/cycle.
- Response lengths:
  - Read: 10 bytes.
  - Write or error: 3 bytes.
- Dropped commands:
  - CmdValid while Busy (any state except IDLE) is dropped; the latched command is unaffected.
  - DropCnt += 1, saturating at 255.
  - CmdValid in the cycle the FSM returns to IDLE (LF accepted) is also dropped.
- Stray BusAck: BusAck outside BUS is ignored.

Test Plan:
- Write: CmdValid with Cmd = 2, CmdAddr = 0x00000010, CmdData = 0xBADC0FEE; ack 3 cycles after BusReq rises.
  - BusReq rises 1 cycle after CmdValid, with BusWe = 1 and BusWData = 0xBADC0FEE.
  - TX sends 0x4B 0x0D 0x0A.
- Read: Cmd = 1, addr 0x20; BusRData = 0x0123ABCD with ack; TxReady always high.
  - TX sends "0123ABCD" then 0x0D 0x0A on 10 consecutive cycles.
  - Busy falls the cycle after LF is accepted.
- Timeout: TIMEOUT_CYCLES = 4, BusAck never asserted.
  - BusReq stays high exactly 4 cycles.
  - TX sends 0x45 0x0D 0x0A.
  - A second case with ack in the 4th cycle produces "K"/hex, not "E".
- Backpressure: TxReady toggles every other cycle during a read response.
  - TxChar holds stable while TxReady is low; no byte is lost or duplicated.
- Drop: 300 CmdValid pulses issued while in BUS.
  - DropCnt saturates at 255; the original transaction completes normally.
  - An invalid Cmd = 4'h0 in IDLE yields "E" CR LF with no BusReq.
- Reset mid-op: RstN low during BUS, then during HEX.
  - BusReq, TxValid and Busy are 0 after that edge; no residual bytes after reset release.
  - The next command executes normally.

Source files
------------

// File: rtl/cmd_bus_sequencer.sv
// cmd_bus_sequencer
//   Runs one decoded ASCII command as a single register-bus transaction and
//   streams an ASCII response towards the UART transmitter.
//
//   Responses:
//     read  -> 8 uppercase hex chars (MS nibble first), CR, LF
//     write -> "K", CR, LF
//     error -> "E", CR, LF  (invalid command or bus timeout)
//
// Ports
//   Clk, RstN                      clock, synchronous active-low reset
//   Cmd, CmdAddr, CmdData,         command from the interpreter; CmdValid is a
//   CmdValid                       single-cycle strobe
//   Busy                           high whenever the sequencer is not idle
//   BusReq, BusWe, BusAddr,        register bus request side
//   BusWData
//   BusAck, BusRData               register bus completion side
//   TxChar, TxValid, TxReady       response byte stream (valid/ready)
//   DropCnt                        saturating count of commands seen while busy
module cmd_bus_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        Clk,
  input  logic        RstN,
  input  logic [3:0]  Cmd,
  input  logic [31:0] CmdAddr,
  input  logic [31:0] CmdData,
  input  logic        CmdValid,
  output logic        Busy,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWData,
  input  logic        BusAck,
  input  logic [31:0] BusRData,
  output logic [7:0]  TxChar,
  output logic        TxValid,
  input  logic        TxReady,
  output logic [7:0]  DropCnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_BUS  = 3'd1;
  localparam logic [2:0] S_HEX  = 3'd2;
  localparam logic [2:0] S_STAT = 3'd3;
  localparam logic [2:0] S_CR   = 3'd4;
  localparam logic [2:0] S_LF   = 3'd5;

  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  // Counter value in the last allowed request cycle: a request that is still
  // unacknowledged here has been high for TIMEOUT_CYCLES cycles.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] to_cnt;
  logic [31:0]      rdata;      // read data, shifted left as nibbles go out
  logic [2:0]       nib_idx;
  logic [7:0]       stat_char;
  logic             tx_fire;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign Busy    = (state != S_IDLE);
  assign BusReq  = (state == S_BUS);
  assign TxValid = (state == S_HEX) || (state == S_STAT) ||
                   (state == S_CR)  || (state == S_LF);
  assign tx_fire = TxValid && TxReady;

  // TxChar is a pure function of state and held registers, so it stays
  // stable for as long as TxReady is withheld.
  always_comb begin
    TxChar = 8'h00;
    case (state)
      S_HEX:   TxChar = hex_char(rdata[31:28]);
      S_STAT:  TxChar = stat_char;
      S_CR:    TxChar = CH_CR;
      S_LF:    TxChar = CH_LF;
      default: TxChar = 8'h00;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      state     <= S_IDLE;
      to_cnt    <= '0;
      rdata     <= '0;
      nib_idx   <= '0;
      stat_char <= '0;
      BusWe     <= 1'b0;
      BusAddr   <= '0;
      BusWData  <= '0;
      DropCnt   <= '0;
    end else begin
      // Any strobe outside IDLE is discarded, including the cycle in which
      // LF is accepted (state is still LF then).
      if (CmdValid && (state != S_IDLE) && (DropCnt != 8'hFF))
        DropCnt <= DropCnt + 8'd1;

      case (state)
        S_IDLE: begin
          to_cnt <= '0;
          if (CmdValid) begin
            if ((Cmd == 4'h1) || (Cmd == 4'h2)) begin
              BusAddr  <= CmdAddr;
              BusWData <= CmdData;
              BusWe    <= (Cmd == 4'h2);
              state    <= S_BUS;
            end else begin
              stat_char <= CH_E;
              state     <= S_STAT;
            end
          end
        end
        S_BUS: begin
          // Ack is checked first so an ack in the expiring cycle wins.
          if (BusAck) begin
            if (BusWe) begin
              stat_char <= CH_K;
              state     <= S_STAT;
            end else begin
              rdata   <= BusRData;
              nib_idx <= '0;
              state   <= S_HEX;
            end
          end else if (to_cnt == TO_LAST) begin
            stat_char <= CH_E;
            state     <= S_STAT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_HEX: if (tx_fire) begin
          rdata   <= {rdata[27:0], 4'h0};
          nib_idx <= nib_idx + 3'd1;
          if (nib_idx == 3'd7) state <= S_CR;
        end
        S_STAT:  if (tx_fire) state <= S_CR;
        S_CR:    if (tx_fire) state <= S_LF;
        S_LF:    if (tx_fire) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_bus_sequencer.sv
module tb_cmd_bus_sequencer;

  logic        Clk = 1'b0;
  logic        RstN;
  logic [3:0]  Cmd;
  logic [31:0] CmdAddr, CmdData;
  logic        CmdValid;
  logic        Busy, BusReq, BusWe;
  logic [31:0] BusAddr, BusWData;
  logic        BusAck;
  logic [31:0] BusRData;
  logic [7:0]  TxChar;
  logic        TxValid, TxReady;
  logic [7:0]  DropCnt;

  int checks = 0;
  int failures = 0;

  logic [7:0] rx [16];
  int rx_n, rx_cyc;
  logic rx_req;

  always #5 Clk = ~Clk;

  cmd_bus_sequencer #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .Clk(Clk), .RstN(RstN), .Cmd(Cmd), .CmdAddr(CmdAddr), .CmdData(CmdData),
    .CmdValid(CmdValid), .Busy(Busy), .BusReq(BusReq), .BusWe(BusWe),
    .BusAddr(BusAddr), .BusWData(BusWData), .BusAck(BusAck),
    .BusRData(BusRData), .TxChar(TxChar), .TxValid(TxValid),
    .TxReady(TxReady), .DropCnt(DropCnt)
  );

  task automatic step();
    @(posedge Clk); #1;
  endtask

  // Issue one command strobe; returns one cycle later with CmdValid low.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    Cmd = c; CmdAddr = a; CmdData = d; CmdValid = 1'b1;
    step();
    CmdValid = 1'b0;
  endtask

  // Gathers accepted bytes with TxReady high; records whether BusReq was seen.
  task automatic collect(input int n, input int bound);
    rx_n = 0; rx_cyc = 0; rx_req = 1'b0; TxReady = 1'b1;
    while (rx_n < n && rx_cyc < bound) begin
      if (BusReq) rx_req = 1'b1;
      if (TxValid) begin
        rx[rx_n] = TxChar;
        rx_n++;
      end
      rx_cyc++;
      step();
    end
    TxReady = 1'b0;
  endtask

  task automatic test_reset();
    RstN = 1'b0; Cmd = '0; CmdAddr = '0; CmdData = '0; CmdValid = 1'b0;
    BusAck = 1'b0; BusRData = '0; TxReady = 1'b0;
    step(); step();
    checks++; if ({Busy, BusReq, BusWe, TxValid} !== 4'b0) begin failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {Busy, BusReq, BusWe, TxValid}); end
    checks++; if ({BusAddr, BusWData, TxChar, DropCnt} !== 80'h0) begin failures++;
      $display("FAIL reset_data got=%h exp=0", {BusAddr, BusWData, TxChar, DropCnt}); end
    RstN = 1'b1;
    step();
  endtask

  task automatic test_write();
    string exp = "K\r\n";
    issue(4'h2, 32'h0000_0010, 32'hBADC_0FEE);
    checks++; if ({BusReq, BusWe} !== 2'b11) begin failures++;
      $display("FAIL wr_req got=%b exp=11", {BusReq, BusWe}); end
    checks++; if (BusWData !== 32'hBADC_0FEE || BusAddr !== 32'h10) begin failures++;
      $display("FAIL wr_bus addr=%h data=%h exp=10/badc0fee", BusAddr, BusWData); end
    step(); step();
    checks++; if (BusReq !== 1'b1) begin failures++;
      $display("FAIL wr_req_hold got=%b exp=1", BusReq); end
    BusAck = 1'b1;
    step();
    BusAck = 1'b0;
    checks++; if (BusReq !== 1'b0) begin failures++;
      $display("FAIL wr_req_drop got=%b exp=0", BusReq); end
    collect(3, 10);
    checks++; if (rx_n !== 3) begin failures++;
      $display("FAIL wr_len got=%0d exp=3", rx_n); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rx[i] !== exp[i]) begin failures++;
        $display("FAIL wr_byte%0d got=%h exp=%h", i, rx[i], exp[i]); end
    end
    checks++; if ({Busy, TxValid} !== 2'b00) begin failures++;
      $display("FAIL wr_idle got=%b exp=00", {Busy, TxValid}); end
  endtask

  task automatic test_read();
    string exp = "0123ABCD\r\n";
    issue(4'h1, 32'h20, 32'h0);
    checks++; if ({BusReq, BusWe} !== 2'b10) begin failures++;
      $display("FAIL rd_req got=%b exp=10", {BusReq, BusWe}); end
    BusAck = 1'b1; BusRData = 32'h0123_ABCD;
    step();
    BusAck = 1'b0; BusRData = '0;
    collect(10, 20);
    checks++; if (rx_n !== 10 || rx_cyc !== 10) begin failures++;
      $display("FAIL rd_len got=%0d/%0d cycles exp=10/10", rx_n, rx_cyc); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (rx[i] !== exp[i]) begin failures++;
        $display("FAIL rd_byte%0d got=%h exp=%h", i, rx[i], exp[i]); end
    end
    checks++; if ({Busy, TxValid} !== 2'b00) begin failures++;
      $display("FAIL rd_idle got=%b exp=00", {Busy, TxValid}); end
  endtask

  task automatic test_timeout();
    string exp = "E\r\n";
    int n = 0;
    issue(4'h1, 32'h30, 32'h0);
    while (BusReq && n < 20) begin n++; step(); end
    checks++; if (n !== 4) begin failures++;
      $display("FAIL to_req_cycles got=%0d exp=4", n); end
    collect(3, 10);
    checks++; if (rx_n !== 3 || rx_req !== 1'b0) begin failures++;
      $display("FAIL to_len got=%0d req=%b exp=3/0", rx_n, rx_req); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rx[i] !== exp[i]) begin failures++;
        $display("FAIL to_byte%0d got=%h exp=%h", i, rx[i], exp[i]); end
    end
  endtask

  task automatic test_timeout_ack();
    string exp = "DEADBEEF\r\n";
    issue(4'h1, 32'h34, 32'h0);
    step(); step(); step();
    BusAck = 1'b1; BusRData = 32'hDEAD_BEEF;   // 4th request cycle
    step();
    BusAck = 1'b0; BusRData = '0;
    collect(10, 20);
    checks++; if (rx_n !== 10) begin failures++;
      $display("FAIL toack_len got=%0d exp=10", rx_n); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (rx[i] !== exp[i]) begin failures++;
        $display("FAIL toack_byte%0d got=%h exp=%h", i, rx[i], exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    string exp = "89ABCDEF\r\n";
    logic [7:0] held = '0;
    logic held_v = 1'b0;
    int got = 0;
    issue(4'h1, 32'h40, 32'h0);
    BusAck = 1'b1; BusRData = 32'h89AB_CDEF;
    step();
    BusAck = 1'b0; BusRData = '0;
    for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
      TxReady = cyc[0];
      if (TxValid) begin
        if (held_v) begin
          checks++; if (TxChar !== held) begin failures++;
            $display("FAIL bp_stable got=%h exp=%h", TxChar, held); end
        end
        if (TxReady) begin rx[got] = TxChar; got++; held_v = 1'b0; end
        else begin held = TxChar; held_v = 1'b1; end
      end
      step();
    end
    TxReady = 1'b0;
    checks++; if (got !== 10) begin failures++;
      $display("FAIL bp_len got=%0d exp=10", got); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (rx[i] !== exp[i]) begin failures++;
        $display("FAIL bp_byte%0d got=%h exp=%h", i, rx[i], exp[i]); end
    end
    checks++; if (Busy !== 1'b0) begin failures++;
      $display("FAIL bp_idle got=%b exp=0", Busy); end
  endtask

  task automatic test_invalid();
    string exp = "E\r\n";
    issue(4'h0, 32'h50, 32'h0);
    collect(3, 10);
    checks++; if (rx_n !== 3 || rx_req !== 1'b0) begin failures++;
      $display("FAIL inv_len got=%0d req=%b exp=3/0", rx_n, rx_req); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rx[i] !== exp[i]) begin failures++;
        $display("FAIL inv_byte%0d got=%h exp=%h", i, rx[i], exp[i]); end
    end
  endtask

  // 300 strobes: three while the request is outstanding, the rest while the
  // "K" byte is held back by TxReady.
  task automatic test_drop();
    string exp = "K\r\n";
    issue(4'h2, 32'h60, 32'h1111_2222);
    Cmd = 4'h1; CmdAddr = 32'hFFFF_0000; CmdData = 32'h0; CmdValid = 1'b1;
    step(); step();
    BusAck = 1'b1;
    step();
    BusAck = 1'b0;
    checks++; if (DropCnt !== 8'd3) begin failures++;
      $display("FAIL drop_bus got=%0d exp=3", DropCnt); end
    checks++; if (BusAddr !== 32'h60 || BusWData !== 32'h1111_2222 || BusWe !== 1'b1) begin failures++;
      $display("FAIL drop_latch addr=%h data=%h we=%b", BusAddr, BusWData, BusWe); end
    for (int i = 0; i < 297; i++) step();
    CmdValid = 1'b0;
    checks++; if (DropCnt !== 8'd255) begin failures++;
      $display("FAIL drop_sat got=%0d exp=255", DropCnt); end
    collect(3, 10);
    for (int i = 0; i < 3; i++) begin
      checks++; if (rx[i] !== exp[i]) begin failures++;
        $display("FAIL drop_byte%0d got=%h exp=%h", i, rx[i], exp[i]); end
    end
  endtask

  task automatic test_reset_midop();
    string exp = "K\r\n";
    int stray = 0;
    issue(4'h1, 32'h70, 32'h0);
    RstN = 1'b0;
    step();
    checks++; if ({BusReq, TxValid, Busy} !== 3'b000) begin failures++;
      $display("FAIL rst_bus got=%b exp=000", {BusReq, TxValid, Busy}); end
    checks++; if (DropCnt !== 8'd0) begin failures++;
      $display("FAIL rst_dropcnt got=%0d exp=0", DropCnt); end
    RstN = 1'b1;
    issue(4'h1, 32'h74, 32'h0);
    BusAck = 1'b1; BusRData = 32'hCAFE_F00D;
    step();
    BusAck = 1'b0;
    collect(2, 5);
    RstN = 1'b0;
    step();
    checks++; if ({BusReq, TxValid, Busy} !== 3'b000) begin failures++;
      $display("FAIL rst_hex got=%b exp=000", {BusReq, TxValid, Busy}); end
    RstN = 1'b1; TxReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (TxValid || Busy || BusReq) stray++;
      step();
    end
    TxReady = 1'b0;
    checks++; if (stray !== 0) begin failures++;
      $display("FAIL rst_residual got=%0d exp=0", stray); end
    issue(4'h2, 32'h78, 32'h5);
    BusAck = 1'b1;
    step();
    BusAck = 1'b0;
    collect(3, 10);
    checks++; if (rx_n !== 3) begin failures++;
      $display("FAIL rst_next_len got=%0d exp=3", rx_n); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rx[i] !== exp[i]) begin failures++;
        $display("FAIL rst_next_byte%0d got=%h exp=%h", i, rx[i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_timeout_ack();
    test_backpressure();
    test_invalid();
    test_drop();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
